// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32IC fetch aligner.
// Imported by the interface, the word buffer and the aligner top.
package fetch_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned WADDR_W = ADDR_W - 2;

   localparam logic [1:0] RVC_FULL = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      FETCH0,
      FETCH1
   } state_e;

   localparam logic [ADDR_W-1:0]  RST_PC_PLUS = ADDR_W'(2);
   localparam logic [WADDR_W-1:0] RST_ADDR    = '0;
   localparam logic [31:0]        RST_DATA    = '0;

endpackage

// File: rtl/fetch_aligner_if.sv
// I-cache word-read port between the fetch aligner and the cache.
// master = aligner side, slave = cache side.
interface fetch_aligner_if;
   import fetch_pkg::*;

   logic               icache_read;
   logic [WADDR_W-1:0] icache_addr;
   logic [31:0]        icache_rdata;
   logic               icache_stall;

   modport master (
      output icache_read,
      output icache_addr,
      input  icache_rdata,
      input  icache_stall
   );

   modport slave (
      input  icache_read,
      input  icache_addr,
      output icache_rdata,
      output icache_stall
   );

endinterface

// File: rtl/fetch_word_buf.sv
// Tagged single-word fetch buffer plus the straddle half register.
// Both are cleared only by reset.
module fetch_word_buf
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fill_i,
   input  logic [WADDR_W-1:0] fill_tag_i,
   input  logic [31:0]        fill_data_i,
   input  logic               half_ld_i,
   input  logic [WADDR_W-1:0] tag_a_i,
   input  logic [WADDR_W-1:0] tag_b_i,
   output logic               hit_a_o,
   output logic               hit_b_o,
   output logic               half_hit_o,
   output logic [31:0]        buf_data_o,
   output logic [15:0]        half_data_o
);

   logic               buf_valid_q;
   logic [WADDR_W-1:0] buf_tag_q;
   logic [31:0]        buf_data_q;
   logic               half_valid_q;
   logic [WADDR_W-1:0] half_tag_q;
   logic [15:0]        half_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_q  <= 1'b0;
         buf_tag_q    <= RST_ADDR;
         buf_data_q   <= RST_DATA;
         half_valid_q <= 1'b0;
         half_tag_q   <= RST_ADDR;
         half_data_q  <= '0;
      end else begin
         if (fill_i) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= fill_tag_i;
            buf_data_q  <= fill_data_i;
         end
         // Capture the upper half of word A before B overwrites the buffer
         if (half_ld_i) begin
            half_valid_q <= 1'b1;
            half_tag_q   <= tag_a_i;
            half_data_q  <= buf_data_q[31:16];
         end
      end
   end

   assign hit_a_o     = buf_valid_q && (buf_tag_q == tag_a_i);
   assign hit_b_o     = buf_valid_q && (buf_tag_q == tag_b_i);
   assign half_hit_o  = half_valid_q && (half_tag_q == tag_a_i);
   assign buf_data_o  = buf_data_q;
   assign half_data_o = half_data_q;

endmodule

// File: rtl/fetch_aligner.sv
// Fetch aligner: turns a halfword-aligned PC into one RV32IC instruction,
// issuing I-cache word reads and stalling the PC until it is available.
module fetch_aligner
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              pc_valid,
   input  logic              flush,
   fetch_aligner_if.master   ic,
   output logic [31:0]       inst,
   output logic              inst_valid,
   output logic              inst_compressed,
   output logic [ADDR_W-1:0] pc_plus,
   output logic              fetch_stall
);

   state_e             state_q, state_d;
   logic [WADDR_W-1:0] addr_q, addr_d;
   logic [WADDR_W-1:0] a_w, b_w;
   logic               hit_a, hit_b, half_hit;
   logic               fill, half_ld, req, deliver;
   logic [31:0]        buf_data, inst_raw;
   logic [15:0]        lo, hi, half_data;
   logic               pc_unused;

   assign a_w       = pc_in[ADDR_W-1:2];
   assign b_w       = a_w + WADDR_W'(1);
   assign lo        = buf_data[15:0];
   assign hi        = buf_data[31:16];
   assign req       = pc_valid & ~flush;
   assign pc_unused = pc_in[0];

   fetch_word_buf u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .fill_i      (fill),
      .fill_tag_i  (addr_q),
      .fill_data_i (ic.icache_rdata),
      .half_ld_i   (half_ld),
      .tag_a_i     (a_w),
      .tag_b_i     (b_w),
      .hit_a_o     (hit_a),
      .hit_b_o     (hit_b),
      .half_hit_o  (half_hit),
      .buf_data_o  (buf_data),
      .half_data_o (half_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= RST_ADDR;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      fill     = 1'b0;
      half_ld  = 1'b0;
      deliver  = 1'b0;
      inst_raw = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               unique case (1'b1)
                  !pc_in[1] && hit_a: begin
                     deliver  = 1'b1;
                     inst_raw = (lo[1:0] != RVC_FULL) ? {16'h0, lo} : buf_data;
                  end
                  pc_in[1] && hit_a && (hi[1:0] != RVC_FULL): begin
                     deliver  = 1'b1;
                     inst_raw = {16'h0, hi};
                  end
                  pc_in[1] && hit_a && (hi[1:0] == RVC_FULL): begin
                     half_ld = 1'b1;
                     addr_d  = b_w;
                     state_d = FETCH1;
                  end
                  pc_in[1] && hit_b && half_hit: begin
                     deliver  = 1'b1;
                     inst_raw = {lo, half_data};
                  end
                  default: begin
                     addr_d  = a_w;
                     state_d = FETCH0;
                  end
               endcase
            end
         end
         // A read in flight always completes, even across flush or PC change
         FETCH0, FETCH1: begin
            if (!ic.icache_stall) begin
               fill    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ic.icache_read   = (state_q != IDLE);
   assign ic.icache_addr   = addr_q;
   assign inst             = inst_raw;
   assign inst_valid       = deliver;
   assign inst_compressed  = deliver & (inst_raw[1:0] != RVC_FULL);
   assign pc_plus          = deliver
                             ? pc_in + (inst_compressed ? ADDR_W'(2) : ADDR_W'(4))
                             : RST_PC_PLUS;
   assign fetch_stall      = req & ~deliver;

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner with a behavioural I-cache model.
module tb_fetch_aligner;
   import fetch_pkg::*;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc_plus;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        flush;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_compressed;
   logic [31:0] pc_plus;
   logic        fetch_stall;

   fetch_aligner_if ifc ();

   fetch_aligner dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_in           (pc_in),
      .pc_valid        (pc_valid),
      .flush           (flush),
      .ic              (ifc.master),
      .inst            (inst),
      .inst_valid      (inst_valid),
      .inst_compressed (inst_compressed),
      .pc_plus         (pc_plus),
      .fetch_stall     (fetch_stall)
   );

   logic [31:0] mem [logic [29:0]];
   int          stall_req;
   int          stall_seen;
   exp_t        sb_q [$];
   int          n_vec;
   int          n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      ifc.icache_rdata = 32'h0;
      if (mem.exists(ifc.icache_addr)) ifc.icache_rdata = mem[ifc.icache_addr];
   end

   always @(posedge clk) stall_seen <= ifc.icache_read ? stall_seen + 1 : 0;
   assign ifc.icache_stall = ifc.icache_read && (stall_seen < stall_req);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      pc_valid = 1'b0;
      flush    = 1'b0;
      pc_in    = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Present pc until delivery; checks stall, read addresses and latency.
   task automatic fetch(input logic [31:0] pc, input logic [31:0] ei,
                        input int elat, input int nrd,
                        input logic [29:0] a0, input logic [29:0] a1);
      exp_t e;
      int   cyc;
      int   rd;
      bit   done;
      e.inst    = ei;
      e.pc_plus = pc + ((ei[1:0] != 2'b11) ? 32'd2 : 32'd4);
      e.lat     = elat;
      sb_q.push_back(e);
      pc_in    = pc;
      pc_valid = 1'b1;
      flush    = 1'b0;
      cyc      = 0;
      rd       = 0;
      done     = 1'b0;
      while (!done && cyc < 30) begin
         @(negedge clk);
         if (ifc.icache_read) begin
            chk("rd_addr", 32'(ifc.icache_addr), 32'((rd == 0) ? a0 : a1));
            if (!ifc.icache_stall) rd++;
         end
         if (inst_valid) begin
            e = sb_q.pop_front();
            chk("inst", inst, e.inst);
            chk("cmp", 32'(inst_compressed), 32'(e.inst[1:0] != 2'b11));
            chk("pc_plus", pc_plus, e.pc_plus);
            chk("latency", cyc, e.lat);
            chk("n_reads", rd, nrd);
            chk("stall_dlv", 32'(fetch_stall), 32'd0);
            done = 1'b1;
         end else begin
            chk("stall_wait", 32'(fetch_stall), 32'd1);
         end
         cyc++;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         chk("timeout", 32'(inst_valid), 32'd1);
         void'(sb_q.pop_front());
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      stall_req = 0;
      rst_n     = 1'b0;
      pc_valid  = 1'b0;
      flush     = 1'b0;
      pc_in     = 32'h0;
      mem[30'h040]      = 32'h00A00093;
      mem[30'h041]      = 32'h00931234;
      mem[30'h042]      = 32'h556600A0;
      mem[30'h080]      = 32'h00100073;
      mem[30'h3FFFFFFF] = 32'h05130001;
      mem[30'h000]      = 32'h00000050;

      #2;
      chk("rst_read", 32'(ifc.icache_read), 32'd0);
      chk("rst_addr", 32'(ifc.icache_addr), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_cmp", 32'(inst_compressed), 32'd0);
      chk("rst_pcp", pc_plus, 32'd2);
      chk("rst_fstall", 32'(fetch_stall), 32'd0);
      do_reset();

      // aligned 32-bit miss, then hit
      fetch(32'h100, 32'h00A00093, 2, 1, 30'h40, 30'h0);
      fetch(32'h100, 32'h00A00093, 0, 0, 30'h0, 30'h0);

      // compressed pair with a flushed hit in between
      do_reset();
      mem[30'h040] = 32'h00854501;
      fetch(32'h100, 32'h00004501, 2, 1, 30'h40, 30'h0);
      pc_in = 32'h102;
      flush = 1'b1;
      @(negedge clk);
      chk("hf_valid", 32'(inst_valid), 32'd0);
      chk("hf_stall", 32'(fetch_stall), 32'd0);
      @(posedge clk);
      #1;
      chk("hf_read", 32'(ifc.icache_read), 32'd0);
      fetch(32'h102, 32'h00000085, 0, 0, 30'h0, 30'h0);

      // straddle with nothing buffered, then compressed hit in B
      do_reset();
      fetch(32'h106, 32'h00A00093, 4, 2, 30'h41, 30'h42);
      fetch(32'h10A, 32'h00005566, 0, 0, 30'h0, 30'h0);

      // cache stall for 3 cycles
      do_reset();
      mem[30'h040] = 32'h00A00093;
      stall_req = 3;
      fetch(32'h100, 32'h00A00093, 5, 1, 30'h40, 30'h0);
      stall_req = 0;

      // flush plus PC redirect while FETCH0 is in flight
      do_reset();
      pc_in    = 32'h100;
      pc_valid = 1'b1;
      @(negedge clk);
      chk("fl_valid0", 32'(inst_valid), 32'd0);
      chk("fl_stall0", 32'(fetch_stall), 32'd1);
      @(posedge clk);
      #1;
      pc_in = 32'h200;
      flush = 1'b1;
      @(negedge clk);
      chk("fl_valid1", 32'(inst_valid), 32'd0);
      chk("fl_stall1", 32'(fetch_stall), 32'd0);
      chk("fl_read", 32'(ifc.icache_read), 32'd1);
      chk("fl_addr", 32'(ifc.icache_addr), 32'h40);
      @(posedge clk);
      #1;
      fetch(32'h200, 32'h00100073, 2, 1, 30'h80, 30'h0);

      // wrap-around straddle, then straddle with A already buffered
      do_reset();
      fetch(32'hFFFFFFFE, 32'h00500513, 4, 2, 30'h3FFFFFFF, 30'h0);
      fetch(32'hFFFFFFFC, 32'h00000001, 2, 1, 30'h3FFFFFFF, 30'h0);
      fetch(32'hFFFFFFFE, 32'h00500513, 2, 1, 30'h0, 30'h0);

      // asynchronous reset in the middle of FETCH0
      do_reset();
      stall_req = 10;
      pc_in     = 32'h100;
      pc_valid  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mr_read_pre", 32'(ifc.icache_read), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_read", 32'(ifc.icache_read), 32'd0);
      chk("mr_addr", 32'(ifc.icache_addr), 32'd0);
      chk("mr_valid", 32'(inst_valid), 32'd0);
      chk("mr_fstall", 32'(fetch_stall), 32'd1);
      chk("mr_pcp", pc_plus, 32'd2);
      stall_req = 0;
      pc_valid  = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
